// File: rtl/add_sub_core.sv
// -----------------------------------------------------------------------------
// add_sub_core
//
// Multi-cycle IEEE-754 single-precision add/subtract core. The caller supplies
// pre-decoded operands (signs, biased exponents, fractions, magnitude order,
// exponent difference and special-value flags). The core aligns the smaller
// operand one bit per cycle, adds or subtracts the mantissas, and normalises one
// bit per cycle. Rounding is truncation. Denormal inputs are flushed to zero and
// subnormal results are never produced.
//
// Ports
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   start_i         request, accepted only when idle
//   sub_i           1 = x - y, 0 = x + y
//   x_sign_i/y_sign_i, x_exp_i/y_exp_i, x_frac_i/y_frac_i   operand fields
//   x_greater_i     |x| > |y|
//   exp_shift_i     |x_exp - y_exp|
//   x_infinity_i, y_infinity_i, x_nan_i, y_nan_i            special flags
//   busy_o          high whenever the core is not idle
//   done_o          one-cycle pulse, result_o valid while high
//   result_o        packed result, held until the next result is written
// -----------------------------------------------------------------------------
module add_sub_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        sub_i,
  input  logic        x_sign_i,
  input  logic        y_sign_i,
  input  logic [7:0]  x_exp_i,
  input  logic [7:0]  y_exp_i,
  input  logic [22:0] x_frac_i,
  input  logic [22:0] y_frac_i,
  input  logic        x_greater_i,
  input  logic [7:0]  exp_shift_i,
  input  logic        x_infinity_i,
  input  logic        y_infinity_i,
  input  logic        x_nan_i,
  input  logic        y_nan_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_e      state_q, state_d;

  // Datapath registers
  logic        sign_q;       // result sign (sign of the larger operand)
  logic        eff_sub_q;    // effective subtraction
  logic [7:0]  exp_q;        // working exponent
  logic [23:0] l_mant_q;     // larger operand mantissa
  logic [23:0] s_mant_q;     // smaller operand mantissa, shifted during ALIGN
  logic [24:0] sum_q;        // sum / difference being normalised
  logic [7:0]  cnt_q;        // remaining alignment shifts
  logic [31:0] result_q;

  // Accept-time decode
  logic        accept;
  logic        y_sign_eff;
  logic        eff_sub;
  logic        special;
  logic        shift_far;
  logic        shift_zero;
  logic [23:0] x_mant;
  logic [23:0] y_mant;
  logic        l_sign;
  logic [7:0]  l_exp;
  logic [23:0] l_mant;
  logic [23:0] s_mant;
  logic [31:0] special_result;

  // Normalisation decode
  logic        norm_finish;
  logic [31:0] norm_word;

  assign accept     = (state_q == IDLE) && start_i;
  assign y_sign_eff = y_sign_i ^ sub_i;
  assign eff_sub    = x_sign_i ^ y_sign_eff;
  assign special    = x_nan_i | y_nan_i | x_infinity_i | y_infinity_i;
  assign shift_far  = exp_shift_i > 8'd24;
  assign shift_zero = exp_shift_i == 8'd0;

  // Denormal operands are flushed: no hidden bit and a zero fraction.
  assign x_mant = (x_exp_i != 8'd0) ? {1'b1, x_frac_i} : 24'd0;
  assign y_mant = (y_exp_i != 8'd0) ? {1'b1, y_frac_i} : 24'd0;

  assign l_sign = x_greater_i ? x_sign_i : y_sign_eff;
  assign l_exp  = x_greater_i ? x_exp_i  : y_exp_i;
  assign l_mant = x_greater_i ? x_mant   : y_mant;
  assign s_mant = x_greater_i ? y_mant   : x_mant;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    special_result = QNAN;
    if (x_nan_i || y_nan_i) begin
      special_result = QNAN;
    end else if (x_infinity_i && y_infinity_i && eff_sub) begin
      special_result = QNAN;
    end else if (x_infinity_i) begin
      special_result = {x_sign_i, 8'hFF, 23'd0};
    end else begin
      special_result = {y_sign_eff, 8'hFF, 23'd0};
    end
  end

  // One normalisation step, first matching rule wins. A carry into bit 24 that
  // would push the exponent to 255 ends immediately as a signed infinity.
  // The zero rule also covers exponent 0, which only a flushed large operand
  // can produce; that keeps the decrement from wrapping.
  always_comb begin
    norm_finish = 1'b0;
    norm_word   = 32'd0;
    if (sum_q[24]) begin
      norm_finish = exp_q >= 8'd254;
      norm_word   = {sign_q, 8'hFF, 23'd0};
    end else if (sum_q == 25'd0) begin
      norm_finish = 1'b1;
      norm_word   = 32'd0;
    end else if (sum_q[23]) begin
      norm_finish = 1'b1;
      norm_word   = {sign_q, exp_q, sum_q[22:0]};
    end else if (exp_q <= 8'd1) begin
      norm_finish = 1'b1;
      norm_word   = {sign_q, 31'd0};
    end
  end

  // State register
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (special) begin
            state_d = DONE;
          end else if (shift_far || shift_zero) begin
            state_d = ADD;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        // The counter reaches zero on this edge.
        if (cnt_q == 8'd1) begin
          state_d = ADD;
        end
      end
      ADD: begin
        state_d = NORM;
      end
      NORM: begin
        if (norm_finish) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= 8'd0;
      l_mant_q  <= 24'd0;
      s_mant_q  <= 24'd0;
      sum_q     <= 25'd0;
      cnt_q     <= 8'd0;
      result_q  <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (special) begin
              result_q <= special_result;
            end else begin
              sign_q    <= l_sign;
              eff_sub_q <= eff_sub;
              exp_q     <= l_exp;
              l_mant_q  <= l_mant;
              s_mant_q  <= shift_far ? 24'd0 : s_mant;
              cnt_q     <= exp_shift_i;
            end
          end
        end
        ALIGN: begin
          // Bits shifted out are discarded: alignment truncates.
          s_mant_q <= s_mant_q >> 1;
          cnt_q    <= cnt_q - 8'd1;
        end
        ADD: begin
          if (eff_sub_q) begin
            sum_q <= {1'b0, l_mant_q} - {1'b0, s_mant_q};
          end else begin
            sum_q <= {1'b0, l_mant_q} + {1'b0, s_mant_q};
          end
        end
        NORM: begin
          if (norm_finish) begin
            result_q <= norm_word;
          end else if (sum_q[24]) begin
            sum_q <= sum_q >> 1;
            exp_q <= exp_q + 8'd1;
          end else begin
            sum_q <= {sum_q[23:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_add_sub_core.sv
// -----------------------------------------------------------------------------
// tb_add_sub_core
//
// Self-checking bench for add_sub_core. A behavioural model computes the result
// and done latency of each operation directly from 32-bit operand words with
// integer arithmetic; a compare process checks busy_o, done_o and result_o on
// every falling clock edge against the expectation of the operation in flight.
// -----------------------------------------------------------------------------
module tb_add_sub_core;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic        sub_i;
  logic        x_sign_i, y_sign_i;
  logic [7:0]  x_exp_i, y_exp_i;
  logic [22:0] x_frac_i, y_frac_i;
  logic        x_greater_i;
  logic [7:0]  exp_shift_i;
  logic        x_infinity_i, y_infinity_i, x_nan_i, y_nan_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  add_sub_core dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .sub_i        (sub_i),
    .x_sign_i     (x_sign_i),
    .y_sign_i     (y_sign_i),
    .x_exp_i      (x_exp_i),
    .y_exp_i      (y_exp_i),
    .x_frac_i     (x_frac_i),
    .y_frac_i     (y_frac_i),
    .x_greater_i  (x_greater_i),
    .exp_shift_i  (exp_shift_i),
    .x_infinity_i (x_infinity_i),
    .y_infinity_i (y_infinity_i),
    .x_nan_i      (x_nan_i),
    .y_nan_i      (y_nan_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake between driver and compare process.
  int          req_id  = 0;   // written by driver
  int          done_id = 0;   // written by compare process
  int          exp_done_cyc;
  logic [31:0] exp_res;
  logic [31:0] held;          // written by compare process
  logic        in_rst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: result word and done latency (cycles after the start
  // cycle) for x op y.
  // ---------------------------------------------------------------------------
  function automatic longint mant_of(input logic [31:0] w);
    return (w[30:23] != 8'd0) ? longint'({1'b1, w[22:0]}) : 64'd0;
  endfunction

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic sub, output logic [31:0] res,
                                output int lat);
    logic   xs, ys, xinf, yinf, xnan, ynan, ls;
    int     xe, ye, le, d, a, n, lz, msb;
    longint lm, sm, sum;
    xs   = x[31];
    ys   = y[31] ^ sub;
    xe   = int'(x[30:23]);
    ye   = int'(y[30:23]);
    xnan = (xe == 255) && (x[22:0] != 23'd0);
    ynan = (ye == 255) && (y[22:0] != 23'd0);
    xinf = (xe == 255) && (x[22:0] == 23'd0);
    yinf = (ye == 255) && (y[22:0] == 23'd0);
    lat  = 1;
    if (xnan || ynan || (xinf && yinf && (xs != ys))) begin
      res = 32'h7FC0_0000;
      return;
    end
    if (xinf) begin
      res = {xs, 8'hFF, 23'd0};
      return;
    end
    if (yinf) begin
      res = {ys, 8'hFF, 23'd0};
      return;
    end
    if (x[30:0] > y[30:0]) begin
      ls = xs; le = xe; lm = mant_of(x); sm = mant_of(y);
    end else begin
      ls = ys; le = ye; lm = mant_of(y); sm = mant_of(x);
    end
    d  = (xe > ye) ? xe - ye : ye - xe;
    a  = (d >= 1 && d <= 24) ? d : 0;
    sm = (d > 24) ? 64'd0 : (sm >> d);
    sum = (xs != ys) ? lm - sm : lm + sm;
    if (sum == 0) begin
      res = 32'd0;
      n   = 1;
    end else if (sum >= 64'h100_0000) begin
      if (le + 1 >= 255) begin
        res = {ls, 8'hFF, 23'd0};
        n   = 1;
      end else begin
        res = {ls, 8'(le + 1), 23'(sum >> 1)};
        n   = 2;
      end
    end else begin
      msb = 0;
      for (int b = 0; b < 24; b++) if (((sum >> b) & 64'd1) != 0) msb = b;
      lz = 23 - msb;
      if (lz <= le - 1) begin
        res = {ls, 8'(le - lz), 23'(sum << lz)};
        n   = lz + 1;
      end else begin
        res = {ls, 31'd0};
        n   = le;
      end
    end
    lat = a + n + 2;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: runs on every falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (in_rst) begin
      done_id = req_id;
      held    = 32'd0;
    end else if (done_id != req_id) begin
      check("busy", 32'(busy_o), 32'd1);
      check("done", 32'(done_o), 32'(cyc == exp_done_cyc));
      if (cyc == exp_done_cyc) begin
        check("result", result_o, exp_res);
        held    = exp_res;
        done_id = req_id;
      end else begin
        check("result_hold", result_o, held);
      end
    end else begin
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_result", result_o, held);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver (all input changes happen 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic launch(input logic [31:0] x, input logic [31:0] y,
                        input logic sub, input logic hold);
    logic [31:0] r;
    int          lat;
    model(x, y, sub, r, lat);
    sub_i        = sub;
    x_sign_i     = x[31];
    y_sign_i     = y[31];
    x_exp_i      = x[30:23];
    y_exp_i      = y[30:23];
    x_frac_i     = x[22:0];
    y_frac_i     = y[22:0];
    x_greater_i  = x[30:0] > y[30:0];
    exp_shift_i  = (x[30:23] >= y[30:23]) ? x[30:23] - y[30:23] : y[30:23] - x[30:23];
    x_infinity_i = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_infinity_i = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_nan_i      = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan_i      = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    start_i      = 1'b1;
    @(posedge clk); #1;        // accept edge
    exp_done_cyc = cyc + lat - 1;
    exp_res      = r;
    req_id       = req_id + 1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (done_id == req_id) break;
    end
    start_i = 1'b0;
    if (k == 300) begin
      check("timeout", 32'(done_id), 32'(req_id));
      in_rst = 1'b1;
      rst_ni = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_ni = 1'b1;
      in_rst = 1'b0;
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic sub, input logic hold);
    launch(x, y, sub, hold);
    wait_done();
  endtask

  function automatic logic [31:0] rand_fp();
    logic        s;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 19))
      0:       return {s, 8'hFF, 23'd0};
      1:       return {s, 8'hFF, (f == 23'd0) ? 23'd1 : f};
      2:       return {s, 8'h00, 23'd0};
      3:       return {s, 8'($urandom_range(250, 254)), f};
      default: return {s, 8'($urandom_range(100, 154)), f};
    endcase
  endfunction

  // Vectors whose results and latencies are worked out by hand.
  logic [31:0] pin_x   [6] = '{32'h3F80_0000, 32'h4040_0000, 32'h3F80_0000,
                               32'h3FC0_0000, 32'h3F80_0000, 32'h7F80_0000};
  logic [31:0] pin_y   [6] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F40_0000,
                               32'h3FC0_0000, 32'h3080_0000, 32'hFF80_0000};
  logic        pin_sub [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] pin_res [6] = '{32'h4000_0000, 32'h4080_0000, 32'h3E80_0000,
                               32'h0000_0000, 32'h3F80_0000, 32'h7FC0_0000};
  int          pin_lat [6] = '{4, 5, 6, 3, 3, 1};

  initial begin
    logic [31:0] r, x, y;
    int          lat;

    in_rst = 1'b1; rst_ni = 1'b0; start_i = 1'b0; sub_i = 1'b0;
    x_sign_i = 1'b0; y_sign_i = 1'b0; x_exp_i = 8'd0; y_exp_i = 8'd0;
    x_frac_i = 23'd0; y_frac_i = 23'd0; x_greater_i = 1'b0; exp_shift_i = 8'd0;
    x_infinity_i = 1'b0; y_infinity_i = 1'b0; x_nan_i = 1'b0; y_nan_i = 1'b0;
    held = 32'd0;

    repeat (3) begin @(posedge clk); #1; end
    in_rst = 1'b0;
    @(posedge clk); #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    rst_ni = 1'b1;

    // Model pinned against hand-worked values; start in the first cycle after
    // reset release.
    for (int i = 0; i < 6; i++) begin
      model(pin_x[i], pin_y[i], pin_sub[i], r, lat);
      check($sformatf("pin_res_%0d", i), r, pin_res[i]);
      check($sformatf("pin_lat_%0d", i), 32'(lat), 32'(pin_lat[i]));
      run_op(pin_x[i], pin_y[i], pin_sub[i], 1'b0);
    end

    // start_i held high during a multi-cycle operation is ignored.
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 1'b1);
    run_op(32'h4B00_0000, 32'h3F80_0000, 1'b1, 1'b1);

    // Reset during ALIGN: no done pulse, reset values restored.
    launch(32'h4B00_0000, 32'h3F80_0000, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("align_busy", 32'(busy_o), 32'd1);
    in_rst = 1'b1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    in_rst = 1'b0;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (30) begin @(posedge clk); #1; end

    // Randomized operations.
    for (int i = 0; i < 250; i++) begin
      x = rand_fp();
      case ($urandom_range(0, 7))
        0:       y = {1'($urandom_range(0, 1)), x[30:0]};
        1:       y = {1'($urandom_range(0, 1)), x[30:23], 23'($urandom)};
        default: y = rand_fp();
      endcase
      run_op(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add_sub_core.md
ADD_SUB_CORE -- requirements
Module: add_sub_core

Interface
REQ-001 SHALL have one clock and synchronous active-low reset: clk_i first, then rst_ni, active low, sampled on rising clk_i.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  request; accepted only in IDLE
- sub_i  in  1  1 = x-y, 0 = x+y
- x_sign_i, y_sign_i  in  1  operand signs
- x_exp_i, y_exp_i  in  8  biased exponents
- x_frac_i, y_frac_i  in  23  fractions
- x_greater_i  in  1  |x| > |y|
- exp_shift_i  in  8  exponent difference, always >= 0
- x_infinity_i, y_infinity_i, x_nan_i, y_nan_i  in  1  special-value flags
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse; result_o is valid while it is high
- result_o  out  32  IEEE-754 single result; held until the next result is written

Function
REQ-003 SHALL capture all inputs on the rising edge where start_i=1 in IDLE (the accept edge); start_i SHALL be ignored outside IDLE.
REQ-004 SHALL have the states IDLE, ALIGN, ADD, NORM, DONE.
REQ-005 Effective subtract: eff_sub = x_sign ^ y_sign ^ sub_i. The y sign used everywhere is y_sign ^ sub_i.
REQ-006 Large operand L SHALL be x when x_greater_i=1, otherwise y. Small operand S is the other one. The result sign is L's sign.
REQ-007 Mantissa = {1,frac} for exp != 0. Operands with exp=0 SHALL be flushed to zero (mantissa 0).
REQ-008 Special cases on accept SHALL go directly to DONE, so done_o is high 1 cycle after accept:
- any NaN -> 0x7FC00000
- inf op inf with eff_sub=1 -> 0x7FC00000
- otherwise, an infinite operand -> signed infinity of that operand (with sub_i applied for y)
REQ-009 On accept, if exp_shift_i > 24, S mantissa SHALL be zeroed and the next state is ADD. If exp_shift_i = 0, the next state is ADD. Otherwise load the shift counter with exp_shift_i and go to ALIGN.
REQ-010 ALIGN SHALL shift the S mantissa right 1 bit per cycle, discarding bits shifted out (truncation), and decrement the counter. It SHALL move to ADD in the cycle the counter reaches 0, so A = shift cycles.
REQ-011 ADD, 1 cycle, SHALL compute a 25-bit sum, L+S or L-S by eff_sub, with the working exponent set to L's exponent, then go to NORM.
REQ-012 NORM SHALL apply the first matching rule each cycle:
- bit24=1: shift right 1, exponent+1.
- sum=0: pack 0x00000000 and go to DONE.
- bit23=1: pack {sign, exp, sum[22:0]} and go to DONE.
- exponent=1: pack signed zero and go to DONE.
- otherwise: shift left 1, exponent-1.
N = total NORM cycles.
REQ-013 If the exponent reaches 255 in NORM, the block SHALL pack signed infinity and go to DONE immediately.
REQ-014 DONE SHALL last 1 cycle with done_o=1 and then return to IDLE. Non-special latency: done_o is high 1+A+N+1 cycles after accept.
REQ-015 Rounding SHALL be truncation only. Subnormal results are never produced.

Reset
REQ-016 With rst_ni=0 at a clock edge, the block SHALL enter IDLE with busy_o=0, done_o=0, result_o=0x00000000, and the counter and datapath registers cleared.
REQ-017 Reset mid-operation SHALL abandon the operation with no done_o pulse. A start_i in the first cycle after reset release SHALL be accepted.

Verification
REQ-018 The bench SHALL cover the following scenarios (operands are x, y):
- 0x3F800000 + 0x3F800000: result 0x40000000, done_o at accept+4 (A=0, N=2).
- 0x40400000 + 0x3F800000: result 0x40800000, done_o at accept+5 (A=1, N=2).
- 0x3F800000 - 0x3F400000: result 0x3E800000, done_o at accept+6 (A=1, N=3).
- 0x3FC00000 - 0x3FC00000: result 0x00000000, done_o at accept+3.
- 0x3F800000 + 0x30800000 (shift 30 > 24): result 0x3F800000, done_o at accept+3.
- +inf + -inf: result 0x7FC00000 at accept+1.
- rst_ni=0 during ALIGN: no done_o, outputs return to their reset values.
- start_i held high while busy: it is ignored.
